sysid_checker: RTL and testbench

Avalon-MM read master that interrogates a system-ID slave (word 0 = ID, word 1 = build timestamp) and checks both words against expected values. Runs once after reset (optional) or on a start pulse. Provides sticky pass/fail/timeout status and the captured words to boot logic and status LEDs. Pairs with the 1-bit-address, 32-bit-readdata sysid control slave.

---
 rtl/sysid_checker_pkg.sv | 26 ++
 rtl/sysid_read_timer.sv | 57 +++++
 rtl/sysid_checker.sv | 217 +++++++++++++++++++++
 tb/tb_sysid_checker.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the system-ID checker and its read timer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sysid_checker_pkg;

    // Checker sequencing states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_CHECK     = 3'd3,
        S_FINISH    = 3'd4
    } state_e;

    // Word addresses inside the system-ID slave
    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    // Width of the per-read timeout counter and of the retry counter
    localparam int TMR_W   = 8;
    localparam int RETRY_W = 2;

    // One data word as returned by the slave
    typedef logic [31:0] word_t;

endpackage

// File: rtl/sysid_read_timer.sv
// Per-read timeout counter plus retry counter for the system-ID checker.
// Latency: expired_o is combinational in the cycle the count would reach TIMEOUT_CYCLES.
// Backpressure: none; counts while tick_i is high, clear_i has priority.
module sysid_read_timer
    import sysid_checker_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int MAX_RETRIES    = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic tick_i,
    input  logic retry_clr_i,
    input  logic retry_inc_i,
    output logic expired_o,
    output logic retries_exhausted_o
);

    localparam logic [TMR_W-1:0]   LAST_COUNT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    logic [TMR_W-1:0]   count_q, count_d;
    logic [RETRY_W-1:0] retries_q, retries_d;

    // Next-state for the cycle counter and the retry counter
    always_comb begin
        count_d   = count_q;
        retries_d = retries_q;
        if (clear_i) begin
            count_d = '0;
        end else if (tick_i) begin
            count_d = count_q + 1'b1;
        end
        if (retry_clr_i) begin
            retries_d = '0;
        end else if (retry_inc_i && (retries_q != RETRY_MAX)) begin
            retries_d = retries_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= '0;
            retries_q <= '0;
        end else begin
            count_q   <= count_d;
            retries_q <= retries_d;
        end
    end

    // The read has used its full budget when this tick would bring the count to TIMEOUT_CYCLES
    assign expired_o           = tick_i && (count_q == LAST_COUNT);
    assign retries_exhausted_o = (retries_q >= RETRY_MAX);

endmodule

// File: rtl/sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID and timestamp words and checks them.
// Latency: zero-wait slave, no readdatavalid: done rises 6 edges after start is sampled.
// Backpressure: address/read held while avm_waitrequest; per-read timeout with bounded retries.
module sysid_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1554394938,
    parameter bit          USE_READDATAVALID  = 1'b0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          MAX_RETRIES        = 2,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_e state_q, state_d;
    logic   word_q, word_d;       // word being fetched: ADDR_ID or ADDR_TS
    logic   gap_q, gap_d;         // one idle cycle between a timed-out read and its retry
    logic   auto_q, auto_d;       // first cycle after reset release
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   pass_q, pass_d;
    logic   id_mm_q, id_mm_d;
    logic   ts_mm_q, ts_mm_d;
    logic   to_q, to_d;
    word_t  cap_q, cap_d;
    word_t  id_val_q, id_val_d;
    word_t  ts_val_q, ts_val_d;

    logic   rd_active;
    logic   accept;
    logic   tmr_tick;
    logic   tmr_clear;
    logic   retry_clr;
    logic   retry_inc;
    logic   expired;
    logic   exhausted;

    // Read strobe is derived from state so an async reset drops it immediately
    assign rd_active = (state_q == S_REQ) && !gap_q;
    assign accept    = rd_active && !avm_waitrequest;

    // The timer runs from the first read assertion until data, and rests otherwise
    assign tmr_tick  = rd_active || (state_q == S_WAIT_DATA);
    assign tmr_clear = !tmr_tick;
    assign retry_clr = (state_q == S_IDLE) || (state_q == S_CHECK);

    sysid_read_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES)
    ) u_timer (
        .clock               (clock),
        .reset_n             (reset_n),
        .clear_i             (tmr_clear),
        .tick_i              (tmr_tick),
        .retry_clr_i         (retry_clr),
        .retry_inc_i         (retry_inc),
        .expired_o           (expired),
        .retries_exhausted_o (exhausted)
    );

    // Next-state and datapath updates; a capture always beats a same-cycle timeout
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        gap_d     = 1'b0;
        auto_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        id_mm_d   = id_mm_q;
        ts_mm_d   = ts_mm_q;
        to_d      = to_q;
        cap_d     = cap_q;
        id_val_d  = id_val_q;
        ts_val_d  = ts_val_q;
        retry_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    id_mm_d = 1'b0;
                    ts_mm_d = 1'b0;
                    to_d    = 1'b0;
                    word_d  = ADDR_ID;
                    busy_d  = 1'b1;
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                if (gap_q) begin
                    state_d = S_REQ;
                end else if (accept) begin
                    if (USE_READDATAVALID) begin
                        state_d = S_WAIT_DATA;
                    end else begin
                        cap_d   = avm_readdata;
                        state_d = S_CHECK;
                    end
                end else if (expired) begin
                    if (!exhausted) begin
                        retry_inc = 1'b1;
                        gap_d     = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        to_d    = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end

            S_WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    cap_d   = avm_readdata;
                    state_d = S_CHECK;
                end else if (expired) begin
                    if (!exhausted) begin
                        retry_inc = 1'b1;
                        gap_d     = 1'b1;
                        state_d   = S_REQ;
                    end else begin
                        to_d    = 1'b1;
                        state_d = S_FINISH;
                    end
                end
            end

            S_CHECK: begin
                if (word_q == ADDR_ID) begin
                    id_val_d = cap_q;
                    id_mm_d  = (cap_q != EXPECTED_ID);
                    word_d   = ADDR_TS;
                    state_d  = S_REQ;
                end else begin
                    ts_val_d = cap_q;
                    ts_mm_d  = (cap_q != EXPECTED_TIMESTAMP);
                    state_d  = S_FINISH;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                pass_d  = !(id_mm_q || ts_mm_q || to_q);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and status registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            word_q   <= ADDR_ID;
            gap_q    <= 1'b0;
            auto_q   <= AUTO_START;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            id_mm_q  <= 1'b0;
            ts_mm_q  <= 1'b0;
            to_q     <= 1'b0;
            cap_q    <= '0;
            id_val_q <= '0;
            ts_val_q <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            gap_q    <= gap_d;
            auto_q   <= auto_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            id_mm_q  <= id_mm_d;
            ts_mm_q  <= ts_mm_d;
            to_q     <= to_d;
            cap_q    <= cap_d;
            id_val_q <= id_val_d;
            ts_val_q <= ts_val_d;
        end
    end

    assign avm_read    = rd_active;
    assign avm_address = word_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = id_mm_q;
    assign ts_mismatch = ts_mm_q;
    assign timeout_err = to_q;
    assign id_value    = id_val_q;
    assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Scoreboard bench for sysid_checker: three instances cover zero-wait/waitstate,
// timeout/retry and readdatavalid configurations.
// Results are checked by a done-edge monitor against queued expectations.
module tb_sysid_checker;
    import sysid_checker_pkg::*;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1554394938;
    localparam logic [31:0] BAD_TS = 32'h5CA6_3A3B;

    typedef struct packed {
        logic        busy;
        logic        pass;
        logic        id_mm;
        logic        ts_mm;
        logic        to;
        logic [31:0] idv;
        logic [31:0] tsv;
    } res_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- instance A: defaults, zero-wait or waitstate slave
    logic        reset_a, start_a, addr_a, read_a, wr_a, rdv_a;
    logic [31:0] rdata_a, idv_a, tsv_a;
    logic        busy_a, done_a, pass_a, idmm_a, tsmm_a, to_a;
    int          wait_cycles_a = 0;
    int          wcnt_a = 0;
    logic [31:0] ts_ret_a = EXP_TS;

    assign rdv_a   = 1'b0;
    assign wr_a    = read_a && (wcnt_a < wait_cycles_a);
    assign rdata_a = addr_a ? ts_ret_a : EXP_ID;

    // waitstate counter of the slave model
    always @(posedge clock) begin
        if (read_a && wr_a) wcnt_a <= wcnt_a + 1;
        else                wcnt_a <= 0;
    end

    sysid_checker u_dut_a (
        .clock(clock), .reset_n(reset_a), .start(start_a),
        .avm_address(addr_a), .avm_read(read_a), .avm_waitrequest(wr_a),
        .avm_readdatavalid(rdv_a), .avm_readdata(rdata_a),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .id_mismatch(idmm_a), .ts_mismatch(tsmm_a), .timeout_err(to_a),
        .id_value(idv_a), .ts_value(tsv_a)
    );

    // ---------------- instance T: short timeout, addr0 stalls forever
    logic        reset_t, start_t, addr_t, read_t, wr_t, rdv_t;
    logic [31:0] rdata_t, idv_t, tsv_t;
    logic        busy_t, done_t, pass_t, idmm_t, tsmm_t, to_t;

    assign rdv_t   = 1'b0;
    assign wr_t    = (addr_t == ADDR_ID);
    assign rdata_t = addr_t ? EXP_TS : EXP_ID;

    sysid_checker #(.TIMEOUT_CYCLES(4), .MAX_RETRIES(2)) u_dut_t (
        .clock(clock), .reset_n(reset_t), .start(start_t),
        .avm_address(addr_t), .avm_read(read_t), .avm_waitrequest(wr_t),
        .avm_readdatavalid(rdv_t), .avm_readdata(rdata_t),
        .busy(busy_t), .done(done_t), .pass(pass_t),
        .id_mismatch(idmm_t), .ts_mismatch(tsmm_t), .timeout_err(to_t),
        .id_value(idv_t), .ts_value(tsv_t)
    );

    // ---------------- instance R: readdatavalid slave, data 2 cycles after accept
    logic        reset_r, start_r, addr_r, read_r, wr_r, rdv_r;
    logic [31:0] rdata_r, idv_r, tsv_r;
    logic        busy_r, done_r, pass_r, idmm_r, tsmm_r, to_r;
    int          dly_r = 0;
    logic        addr_l_r = 1'b0;
    logic        spur_r = 1'b0;

    assign wr_r    = 1'b0;
    assign rdv_r   = (dly_r == 1) || spur_r;
    assign rdata_r = (dly_r == 1) ? (addr_l_r ? EXP_TS : EXP_ID) : 32'hDEAD_BEEF;

    // pipelined response of the slave model; not reset so stale data can escape a reset
    always @(posedge clock) begin
        if (read_r && !wr_r) begin
            dly_r    <= 2;
            addr_l_r <= addr_r;
        end else if (dly_r != 0) begin
            dly_r <= dly_r - 1;
        end
    end

    sysid_checker #(.USE_READDATAVALID(1'b1), .AUTO_START(1'b0)) u_dut_r (
        .clock(clock), .reset_n(reset_r), .start(start_r),
        .avm_address(addr_r), .avm_read(read_r), .avm_waitrequest(wr_r),
        .avm_readdatavalid(rdv_r), .avm_readdata(rdata_r),
        .busy(busy_r), .done(done_r), .pass(pass_r),
        .id_mismatch(idmm_r), .ts_mismatch(tsmm_r), .timeout_err(to_r),
        .id_value(idv_r), .ts_value(tsv_r)
    );

    // ---------------- scoreboard
    res_t exp_a[$];
    res_t exp_t[$];
    res_t exp_r[$];

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    function automatic res_t mk(input logic p, input logic im, input logic tm, input logic to,
                                input logic [31:0] iv, input logic [31:0] tv);
        res_t r;
        r.busy  = 1'b0;
        r.pass  = p;
        r.id_mm = im;
        r.ts_mm = tm;
        r.to    = to;
        r.idv   = iv;
        r.tsv   = tv;
        return r;
    endfunction

    function automatic res_t get_res(input int w);
        res_t r;
        case (w)
            0:       r = '{busy_a, pass_a, idmm_a, tsmm_a, to_a, idv_a, tsv_a};
            1:       r = '{busy_t, pass_t, idmm_t, tsmm_t, to_t, idv_t, tsv_t};
            default: r = '{busy_r, pass_r, idmm_r, tsmm_r, to_r, idv_r, tsv_r};
        endcase
        return r;
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0:       return done_a;
            1:       return done_t;
            default: return done_r;
        endcase
    endfunction

    task automatic take(input int w);
        res_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        case (w)
            0: if (exp_a.size() > 0) begin e = exp_a.pop_front(); have = 1'b1; end
            1: if (exp_t.size() > 0) begin e = exp_t.pop_front(); have = 1'b1; end
            default: if (exp_r.size() > 0) begin e = exp_r.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done dut%0d: done rose, no expected result queued", w);
        end else begin
            check($sformatf("result_dut%0d", w), get_res(w), e);
        end
    endtask

    // monitor: compare the status bundle each time done rises
    logic [2:0] prev_done = 3'b000;
    always @(negedge clock) begin
        for (int w = 0; w < 3; w++) begin
            if (get_done(w) && !prev_done[w]) take(w);
            prev_done[w] = get_done(w);
        end
    end

    // address/read stability and waitstate accounting on instance A
    int   stab_err_a = 0;
    int   ws_seen_a  = 0;
    logic p_rd_a = 1'b0, p_wr_a = 1'b0, p_addr_a = 1'b0;
    always @(negedge clock) begin
        if (read_a && wr_a) ws_seen_a++;
        if (p_rd_a && p_wr_a && (!read_a || (addr_a != p_addr_a))) stab_err_a++;
        p_rd_a   = read_a;
        p_wr_a   = wr_a;
        p_addr_a = addr_a;
    end

    // ---------------- stimulus helpers
    task automatic set_start(input int w, input logic v);
        case (w)
            0:       start_a = v;
            1:       start_t = v;
            default: start_r = v;
        endcase
    endtask

    task automatic pulse_start(input int w);
        @(negedge clock);
        set_start(w, 1'b1);
        @(negedge clock);
        set_start(w, 1'b0);
    endtask

    task automatic wait_done(input int w, input int budget, inout int edges);
        while (!get_done(w) && (edges < budget)) begin
            @(negedge clock);
            edges++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b0; start_a = 1'b0;
        reset_t = 1'b0; start_t = 1'b0;
        reset_r = 1'b0; start_r = 1'b0;
        fork
            begin : seq_a
                int e;
                int ws0, se0;
                repeat (3) @(negedge clock);
                check("a_reset_ctrl", {read_a, addr_a, busy_a, done_a, pass_a, idmm_a, tsmm_a, to_a}, 0);
                check("a_reset_values", {idv_a, tsv_a}, 0);
                exp_a.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, EXP_ID, EXP_TS));
                reset_a = 1'b1;
                e = 0;
                wait_done(0, 40, e);
                check("a_autostart_done_edge", e, 6);

                ts_ret_a = BAD_TS;
                exp_a.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, EXP_ID, BAD_TS));
                pulse_start(0);
                e = 1;
                wait_done(0, 40, e);
                check("a_mismatch_done_edge", e, 6);

                ts_ret_a      = EXP_TS;
                wait_cycles_a = 3;
                ws0 = ws_seen_a;
                se0 = stab_err_a;
                exp_a.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, EXP_ID, EXP_TS));
                pulse_start(0);
                e = 1;
                wait_done(0, 60, e);
                check("a_waitstate_done_edge", e, 12);
                check("a_waitstate_cycles", ws_seen_a - ws0, 6);
                check("a_addr_read_stable", stab_err_a - se0, 0);
            end

            begin : seq_t
                int et, att, high, gap, a1;
                logic prv;
                repeat (3) @(negedge clock);
                exp_t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
                reset_t = 1'b1;
                et = 0; att = 0; high = 0; gap = 0; a1 = 0; prv = 1'b0;
                while (!done_t && (et < 80)) begin
                    @(negedge clock);
                    et++;
                    if (read_t) begin
                        if (!prv && (att > 0)) check("t_retry_gap", gap, 1);
                        if (!prv) att++;
                        high++;
                        if (addr_t) a1++;
                    end else begin
                        if (prv) gap = 1;
                        else     gap++;
                    end
                    prv = read_t;
                end
                check("t_attempts", att, 3);
                check("t_read_high_cycles", high, 12);
                check("t_no_addr1_read", a1, 0);
                check("t_done_edge", et, 16);

                pulse_start(1);
                check("t_read_before_reset", read_t, 1'b1);
                #2 reset_t = 1'b0;
                #1;
                check("t_async_reset_drop", {read_t, busy_t}, 2'b00);
                @(negedge clock);
                exp_t.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0));
                reset_t = 1'b1;
                et = 0;
                wait_done(1, 80, et);
                check("t_autostart_after_reset", et, 16);
            end

            begin : seq_r
                int er;
                repeat (3) @(negedge clock);
                reset_r = 1'b1;
                repeat (6) @(negedge clock);
                check("r_no_autostart", {busy_r, done_r}, 0);
                spur_r = 1'b1;
                @(negedge clock);
                spur_r = 1'b0;
                repeat (2) @(negedge clock);
                check("r_spurious_before_run", {busy_r, done_r, idv_r}, 0);

                exp_r.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, EXP_ID, EXP_TS));
                pulse_start(2);
                er = 1;
                wait_done(2, 60, er);
                check("r_done_edge", er, 10);
                spur_r = 1'b1;
                @(negedge clock);
                spur_r = 1'b0;
                repeat (2) @(negedge clock);
                check("r_spurious_after_run", {busy_r, done_r, pass_r, idv_r, tsv_r},
                      {1'b0, 1'b1, 1'b1, EXP_ID, EXP_TS});

                pulse_start(2);
                check("r_req_read", read_r, 1'b1);
                @(negedge clock);
                check("r_in_wait_data", {read_r, busy_r}, 2'b01);
                #1 reset_r = 1'b0;
                #1;
                check("r_reset_clears", {read_r, addr_r, busy_r, done_r, pass_r, idmm_r, tsmm_r, to_r,
                                         idv_r, tsv_r}, 0);
                @(negedge clock);
                reset_r = 1'b1;
                repeat (4) @(negedge clock);
                check("r_stale_rdv_ignored", {busy_r, done_r}, 0);

                exp_r.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, EXP_ID, EXP_TS));
                pulse_start(2);
                er = 1;
                @(negedge clock);
                er++;
                start_r = 1'b1;
                @(negedge clock);
                start_r = 1'b0;
                er++;
                wait_done(2, 60, er);
                check("r_double_start_done_edge", er, 10);
                repeat (6) @(negedge clock);
                check("r_second_start_ignored", {busy_r, done_r}, 2'b01);
            end
        join

        repeat (2) @(negedge clock);
        check("a_queue_drained", exp_a.size(), 0);
        check("t_queue_drained", exp_t.size(), 0);
        check("r_queue_drained", exp_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
